// File: rtl/adc_ltc2311_conv_scheduler.sv
// LTC2311 conversion scheduler.
// Round-robin arbitration of trigger requests, then one CNV pulse, an optional
// conversion wait, a start pulse to the LVDS acquisition engine and a bounded
// wait for its completion.
module adc_ltc2311_conv_scheduler #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16,
    parameter int HI_W  = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     enable_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [HI_W-1:0]          cfg_cnv_high_i,
    input  logic [CNT_W-1:0]         cfg_conv_wait_i,
    input  logic [CNT_W-1:0]         cfg_timeout_i,
    input  logic                     acq_done_i,
    output logic                     cnv_o,
    output logic                     acq_start_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(N_REQ)-1:0] done_src_o,
    output logic                     timeout_o,
    output logic [N_REQ-1:0]         overrun_o,
    output logic [N_REQ-1:0]         pending_o
);

    localparam int IDX_W = $clog2(N_REQ);
    // One shared counter serves the CNV, WAIT and ACQ phases.
    localparam int CW    = (HI_W > CNT_W) ? HI_W : CNT_W;
    localparam int CW1   = CW + 1;

    typedef enum logic [2:0] {S_IDLE, S_CNV, S_WAIT, S_ACQ, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [N_REQ-1:0]   overrun_q, overrun_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [IDX_W-1:0]   done_src_q, done_src_d;
    logic [HI_W-1:0]    hi_q, hi_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   to_q, to_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               acq_start_q, acq_start_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;

    logic               found;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   grant_vec;
    logic [CW1-1:0]     cnt_inc;
    logic [CW1-1:0]     hi_eff;

    assign cnt_inc = {1'b0, cnt_q} + CW1'(1);
    // A programmed CNV high time of 0 still produces a one-cycle pulse.
    assign hi_eff  = (hi_q == '0) ? CW1'(1) : CW1'(hi_q);

    // Round-robin search: first pending bit after the last grant, with wrap.
    always_comb begin
        logic [IDX_W-1:0] idx;
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDX_W'((int'(last_q) + i) % N_REQ);
            if (!found && pending_q[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Sequencer next state, pending latch and single-cycle status pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        last_d      = last_q;
        hi_d        = hi_q;
        wait_d      = wait_q;
        to_d        = to_q;
        done_src_d  = done_src_q;
        acq_start_d = 1'b0;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        grant_vec   = '0;

        case (state_q)
            S_IDLE: begin
                if (enable_i && found) begin
                    grant_vec = N_REQ'(1) << win_idx;
                    src_d     = win_idx;
                    last_d    = win_idx;
                    // Configuration is frozen for the whole sequence.
                    hi_d      = cfg_cnv_high_i;
                    wait_d    = cfg_conv_wait_i;
                    to_d      = cfg_timeout_i;
                    cnt_d     = '0;
                    state_d   = S_CNV;
                end
            end
            S_CNV: begin
                if (cnt_inc >= hi_eff) begin
                    cnt_d = '0;
                    if (wait_q != '0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d     = S_ACQ;
                        acq_start_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            S_WAIT: begin
                if (cnt_inc >= CW1'(wait_q)) begin
                    cnt_d       = '0;
                    state_d     = S_ACQ;
                    acq_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            S_ACQ: begin
                // Completion takes priority over a timeout in the same cycle.
                if (acq_done_i) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    done_src_d = src_q;
                end else if ((to_q != '0) && (cnt_inc >= CW1'(to_q))) begin
                    state_d    = S_IDLE;
                    timeout_d  = 1'b1;
                    done_src_d = src_q;
                end else if (to_q != '0) begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A request on the granted bit in the grant cycle re-arms it.
        pending_d = (pending_q & ~grant_vec) | req_i;
        overrun_d = req_i & pending_q;
    end

    // State and output registers; last_grant resets to N_REQ-1 so source 0 wins first.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            overrun_q   <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            src_q       <= '0;
            done_src_q  <= '0;
            hi_q        <= '0;
            wait_q      <= '0;
            to_q        <= '0;
            cnt_q       <= '0;
            acq_start_q <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            last_q      <= last_d;
            src_q       <= src_d;
            done_src_q  <= done_src_d;
            hi_q        <= hi_d;
            wait_q      <= wait_d;
            to_q        <= to_d;
            cnt_q       <= cnt_d;
            acq_start_q <= acq_start_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cnv_o       = (state_q == S_CNV);
    assign busy_o      = (state_q != S_IDLE);
    assign acq_start_o = acq_start_q;
    assign done_o      = done_q;
    assign done_src_o  = done_src_q;
    assign timeout_o   = timeout_q;
    assign overrun_o   = overrun_q;
    assign pending_o   = pending_q;

endmodule

// File: tb/tb_adc_ltc2311_conv_scheduler.sv
// Testbench for adc_ltc2311_conv_scheduler: scenario tasks plus a completion scoreboard.
module tb_adc_ltc2311_conv_scheduler;

    localparam int N_REQ = 4;
    localparam int CNT_W = 16;
    localparam int HI_W  = 8;

    logic             ACLK = 1'b0;
    logic             ARESETN;
    logic             enable_i;
    logic [N_REQ-1:0] req_i;
    logic [HI_W-1:0]  cfg_cnv_high_i;
    logic [CNT_W-1:0] cfg_conv_wait_i;
    logic [CNT_W-1:0] cfg_timeout_i;
    logic             acq_done_i;
    logic             cnv_o;
    logic             acq_start_o;
    logic             busy_o;
    logic             done_o;
    logic [1:0]       done_src_o;
    logic             timeout_o;
    logic [N_REQ-1:0] overrun_o;
    logic [N_REQ-1:0] pending_o;

    logic ack_man;
    logic auto_ack;

    // Immediate responder: completes on the first ACQ cycle when enabled.
    assign acq_done_i = auto_ack ? acq_start_o : ack_man;

    typedef struct {
        logic [1:0] src;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    adc_ltc2311_conv_scheduler #(
        .N_REQ(N_REQ), .CNT_W(CNT_W), .HI_W(HI_W)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .enable_i       (enable_i),
        .req_i          (req_i),
        .cfg_cnv_high_i (cfg_cnv_high_i),
        .cfg_conv_wait_i(cfg_conv_wait_i),
        .cfg_timeout_i  (cfg_timeout_i),
        .acq_done_i     (acq_done_i),
        .cnv_o          (cnv_o),
        .acq_start_o    (acq_start_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .done_src_o     (done_src_o),
        .timeout_o      (timeout_o),
        .overrun_o      (overrun_o),
        .pending_o      (pending_o)
    );

    always #5 ACLK = ~ACLK;

    // Scoreboard: every completion or timeout pops one expected entry.
    always @(negedge ACLK) begin : mon
        exp_t e;
        if (ARESETN === 1'b1 && (done_o === 1'b1 || timeout_o === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_completion: done=%0b timeout=%0b src=%0d, none expected",
                         done_o, timeout_o, done_src_o);
            end else begin
                e = exp_q.pop_front();
                if (done_src_o !== e.src) begin
                    errors++;
                    $display("FAIL done_src: got %0d, want %0d", done_src_o, e.src);
                end
                checks++;
                if ({done_o, timeout_o} !== {~e.tmo, e.tmo}) begin
                    errors++;
                    $display("FAIL completion_kind: done/timeout got %b, want %b",
                             {done_o, timeout_o}, {~e.tmo, e.tmo});
                end
            end
        end
    end

    task automatic do_reset();
        ARESETN  = 1'b0;
        exp_q.delete();
        auto_ack = 1'b0;
        ack_man  = 1'b0;
        req_i    = '0;
        enable_i = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARESETN         = 1'b0;
        enable_i        = 1'b1;
        req_i           = '0;
        ack_man         = 1'b0;
        auto_ack        = 1'b0;
        cfg_cnv_high_i  = 8'd1;
        cfg_conv_wait_i = '0;
        cfg_timeout_i   = '0;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({cnv_o, acq_start_o, busy_o, done_o, timeout_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cnv/start/busy/done/tmo got %b, want 00000",
                     {cnv_o, acq_start_o, busy_o, done_o, timeout_o});
        end
        checks++;
        if ({pending_o, overrun_o, done_src_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_vectors: pending=%b overrun=%b src=%0d, want all 0",
                     pending_o, overrun_o, done_src_o);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_single();
        int   rise = -1, fall = -1, len = 0, acq_t = -1, done_t = -1, ack_t = -1;
        logic busy_after = 1'bx;
        do_reset();
        cfg_cnv_high_i  = 8'd3;
        cfg_conv_wait_i = 16'd5;
        cfg_timeout_i   = '0;
        req_i = 4'b0001;
        exp_q.push_back('{src: 2'd0, tmo: 1'b0});
        for (int c = 1; c <= 40; c++) begin
            @(negedge ACLK);
            req_i = '0;
            if (cnv_o) begin
                len++;
                if (rise < 0) rise = c;
            end else if (rise >= 0 && fall < 0) begin
                fall = c;
            end
            if (acq_start_o && acq_t < 0) acq_t = c;
            if (done_o && done_t < 0) done_t = c;
            if (done_t >= 0 && c == done_t + 1) busy_after = busy_o;
            ack_man = (acq_t >= 0 && c == acq_t + 10);
            if (ack_man) ack_t = c;
        end
        ack_man = 1'b0;
        checks++;
        if (len != 3) begin errors++; $display("FAIL single_cnv_len: got %0d, want 3", len); end
        checks++;
        if (rise != 2) begin errors++; $display("FAIL single_cnv_rise: cycle %0d, want 2", rise); end
        checks++;
        if (acq_t - fall != 5) begin
            errors++; $display("FAIL single_wait: acq_start %0d cycles after cnv fall, want 5", acq_t - fall);
        end
        checks++;
        if (done_t - ack_t != 1) begin
            errors++; $display("FAIL single_done_lat: %0d cycles after acq_done, want 1", done_t - ack_t);
        end
        checks++;
        if (busy_after !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b, want 0", busy_after); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing: %0d outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        do_reset();
        cfg_cnv_high_i  = 8'd1;
        cfg_conv_wait_i = '0;
        cfg_timeout_i   = '0;
        auto_ack = 1'b1;
        req_i = 4'b1111;
        for (int s = 0; s < 4; s++) exp_q.push_back('{src: 2'(s), tmo: 1'b0});
        for (int c = 1; c <= 30; c++) begin
            @(negedge ACLK);
            req_i = '0;
            if (c == 2 || c == 6 || c == 10 || c == 14) begin
                case (c)
                    2:       want = 4'b1110;
                    6:       want = 4'b1100;
                    10:      want = 4'b1000;
                    default: want = 4'b0000;
                endcase
                checks++;
                if (pending_o !== want) begin
                    errors++; $display("FAIL rr_pending@%0d: got %b, want %b", c, pending_o, want);
                end
            end
        end
        auto_ack = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rr_missing: %0d outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_fairness();
        logic ovr2 = 1'b0;
        do_reset();
        cfg_cnv_high_i  = 8'd1;
        cfg_conv_wait_i = '0;
        cfg_timeout_i   = '0;
        auto_ack = 1'b1;
        req_i = 4'b0101;
        exp_q.push_back('{src: 2'd0, tmo: 1'b0});
        exp_q.push_back('{src: 2'd2, tmo: 1'b0});
        exp_q.push_back('{src: 2'd0, tmo: 1'b0});
        exp_q.push_back('{src: 2'd0, tmo: 1'b0});
        for (int c = 1; c <= 30; c++) begin
            @(negedge ACLK);
            if (overrun_o[2]) ovr2 = 1'b1;
            if (c == 1) begin
                checks++;
                if (overrun_o !== 4'b0000) begin errors++; $display("FAIL fair_overrun@1: got %b, want 0000", overrun_o); end
            end
            if (c == 2) begin
                checks++;
                if (overrun_o !== 4'b0001) begin errors++; $display("FAIL fair_overrun@2: got %b, want 0001", overrun_o); end
            end
            req_i = (c <= 10) ? 4'b0001 : 4'b0000;
        end
        auto_ack = 1'b0;
        checks++;
        if (ovr2 !== 1'b0) begin errors++; $display("FAIL fair_overrun2: got 1, want 0"); end
        checks++;
        if (pending_o !== 4'b0000) begin errors++; $display("FAIL fair_pending_end: got %b, want 0000", pending_o); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fair_missing: %0d outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int   acq_t = -1, tmo_t = -1;
        logic done_before = 1'b0, busy_at_tmo = 1'bx, cnv_next = 1'bx;
        do_reset();
        cfg_cnv_high_i  = 8'd1;
        cfg_conv_wait_i = '0;
        cfg_timeout_i   = 16'd20;
        req_i = 4'b0001;
        exp_q.push_back('{src: 2'd0, tmo: 1'b1});
        exp_q.push_back('{src: 2'd2, tmo: 1'b0});
        for (int c = 1; c <= 50; c++) begin
            @(negedge ACLK);
            req_i = (c == 3) ? 4'b0100 : 4'b0000;
            if (acq_start_o && acq_t < 0) acq_t = c;
            if (done_o && tmo_t < 0) done_before = 1'b1;
            if (tmo_t >= 0 && c == tmo_t + 1) cnv_next = cnv_o;
            if (timeout_o && tmo_t < 0) begin
                tmo_t       = c;
                busy_at_tmo = busy_o;
                auto_ack    = 1'b1;
            end
        end
        auto_ack = 1'b0;
        checks++;
        if (tmo_t - acq_t != 20) begin
            errors++; $display("FAIL tmo_delay: %0d cycles after acq_start, want 20", tmo_t - acq_t);
        end
        checks++;
        if (done_before !== 1'b0) begin errors++; $display("FAIL tmo_done: got done pulse, want none"); end
        checks++;
        if (busy_at_tmo !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b, want 0", busy_at_tmo); end
        checks++;
        if (cnv_next !== 1'b1) begin errors++; $display("FAIL tmo_next_grant: cnv got %b, want 1", cnv_next); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL tmo_missing: %0d outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_boundaries();
        int   len = 0, last_hi = -1, acq_t = -1, done_t = -1;
        logic tmo_seen = 1'b0;
        do_reset();
        cfg_cnv_high_i  = 8'd0;
        cfg_conv_wait_i = '0;
        cfg_timeout_i   = 16'd6;
        req_i = 4'b0001;
        exp_q.push_back('{src: 2'd0, tmo: 1'b0});
        for (int c = 1; c <= 30; c++) begin
            @(negedge ACLK);
            req_i = '0;
            if (cnv_o) begin len++; last_hi = c; end
            if (acq_start_o && acq_t < 0) acq_t = c;
            if (done_o && done_t < 0) done_t = c;
            if (timeout_o) tmo_seen = 1'b1;
            ack_man = (acq_t >= 0 && c == acq_t + 5);
        end
        ack_man = 1'b0;
        checks++;
        if (len != 1) begin errors++; $display("FAIL bnd_cnv_zero: high %0d cycles, want 1", len); end
        checks++;
        if (acq_t != last_hi + 1) begin
            errors++; $display("FAIL bnd_wait_zero: acq_start at %0d, want %0d", acq_t, last_hi + 1);
        end
        checks++;
        if (done_t != acq_t + 6) begin
            errors++; $display("FAIL bnd_coincide_done: done at %0d, want %0d", done_t, acq_t + 6);
        end
        checks++;
        if (tmo_seen !== 1'b0) begin errors++; $display("FAIL bnd_coincide_tmo: got timeout, want none"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bnd_missing: %0d outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_enable();
        logic busy_seen = 1'b0, cnv11 = 1'bx;
        logic [3:0] pend13 = 'x;
        do_reset();
        enable_i        = 1'b0;
        cfg_cnv_high_i  = 8'd1;
        cfg_conv_wait_i = '0;
        cfg_timeout_i   = '0;
        auto_ack = 1'b1;
        req_i = 4'b0010;
        exp_q.push_back('{src: 2'd1, tmo: 1'b0});
        for (int c = 1; c <= 20; c++) begin
            @(negedge ACLK);
            req_i = '0;
            if (c <= 10 && (busy_o || cnv_o)) busy_seen = 1'b1;
            if (c == 10) begin
                checks++;
                if (pending_o !== 4'b0010) begin errors++; $display("FAIL en_pending_held: got %b, want 0010", pending_o); end
                enable_i = 1'b1;
            end
            if (c == 11) cnv11 = cnv_o;
            if (c == 13) pend13 = pending_o;
        end
        auto_ack = 1'b0;
        checks++;
        if (busy_seen !== 1'b0) begin errors++; $display("FAIL en_no_grant: got busy while disabled, want idle"); end
        checks++;
        if (cnv11 !== 1'b1) begin errors++; $display("FAIL en_start: cnv got %b, want 1", cnv11); end
        checks++;
        if (pend13 !== 4'b0000) begin errors++; $display("FAIL en_pending_clr: got %b, want 0000", pend13); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL en_missing: %0d outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg_cnv_high_i  = 8'd2;
        cfg_conv_wait_i = 16'd10;
        cfg_timeout_i   = '0;
        req_i = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            @(negedge ACLK);
            req_i = (c == 3) ? 4'b1000 : 4'b0000;
        end
        req_i = '0;
        checks++;
        if (busy_o !== 1'b1 || pending_o !== 4'b1000) begin
            errors++; $display("FAIL rst_pre_wait: busy=%b pending=%b, want 1 and 1000", busy_o, pending_o);
        end
        ARESETN = 1'b0;
        #1;
        checks++;
        if ({cnv_o, busy_o} !== 2'b00 || pending_o !== 4'b0000) begin
            errors++; $display("FAIL rst_in_wait: cnv=%b busy=%b pending=%b, want 0 0 0000", cnv_o, busy_o, pending_o);
        end
        exp_q.delete();
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        req_i = 4'b0001;
        @(negedge ACLK);
        req_i = '0;
        @(negedge ACLK);
        checks++;
        if (cnv_o !== 1'b1) begin errors++; $display("FAIL rst_pre_cnv: cnv got %b, want 1", cnv_o); end
        ARESETN = 1'b0;
        #1;
        checks++;
        if (cnv_o !== 1'b0) begin errors++; $display("FAIL rst_in_cnv: cnv got %b, want 0", cnv_o); end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_timeout();
        test_boundaries();
        test_enable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_ltc2311_conv_scheduler.md
Name: adc_ltc2311_conv_scheduler

Overview:
- Arbitrates conversion trigger requests from up to N_REQ sources (PWM sync, software trigger, timer) and sequences one LTC2311 conversion at a time.
- Sequence per conversion: drive the CNV pulse, wait the conversion time, start the LVDS serial acquisition engine, await completion.
- Sits between the trigger sources and the existing LVDS acquisition datapath.
- Cycle-count configuration comes from the AXI4-Lite register bank.

Parameters:
- N_REQ, 4, number of trigger requesters (2..8).
- CNT_W, 16, width of the wait and timeout counters.
- HI_W, 8, width of the CNV-high counter.

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  reset, asynchronous, active-low
- enable_i  in  1  1 = grants allowed; pending requests are kept while 0
- req_i  in  N_REQ  trigger pulses, one bit per source, sampled every cycle
- cfg_cnv_high_i  in  HI_W  CNV high time in cycles; 0 is treated as 1
- cfg_conv_wait_i  in  CNT_W  cycles between CNV falling and acq_start; 0 means none
- cfg_timeout_i  in  CNT_W  maximum cycles in ACQ; 0 disables the timeout
- acq_done_i  in  1  one-cycle pulse from the acquisition engine when data is captured
- cnv_o  out  1  ADC convert strobe
- acq_start_o  out  1  one-cycle start pulse to the acquisition engine
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse when a conversion completes
- done_src_o  out  clog2(N_REQ)  index of the source served by the last completion or timeout
- timeout_o  out  1  one-cycle pulse when ACQ is aborted by the timeout
- overrun_o  out  N_REQ  one-cycle pulse per source whose request arrived while its pending bit was already set
- pending_o  out  N_REQ  current pending request vector

Behaviour:
- Reset: all outputs 0, state IDLE, pending = 0, last_grant = N_REQ-1 (so source 0 wins first).
- Pending latch:
  - pending |= req_i every cycle.
  - On a grant, the granted bit clears in the same cycle. A req_i on that same bit in the same cycle re-sets it, so set wins.
  - overrun_o[k] pulses when req_i[k] = 1 and pending[k] is already 1 (registered, one cycle later).
- Arbitration (round-robin, IDLE only):
  - Condition: enable_i = 1 and pending != 0.
  - Grant goes to the first set bit searching from last_grant+1 with wrap-around.
  - last_grant and the internal src register update on the grant.
- IDLE → CNV on grant.
  - cnv_o rises on the cycle after the grant (registered).
- CNV:
  - cnv_o = 1 for exactly max(cfg_cnv_high_i, 1) cycles.
  - Then go to WAIT if cfg_conv_wait_i != 0, otherwise to ACQ.
  - Config values are captured at grant and held for the whole sequence.
- WAIT:
  - cnv_o = 0.
  - Count cfg_conv_wait_i cycles, then go to ACQ.
- ACQ:
  - acq_start_o = 1 on the first ACQ cycle only.
  - Wait for acq_done_i. acq_done_i in any other state is ignored.
  - If acq_done_i = 1: go to DONE.
  - If the timeout is enabled and the cycle count in ACQ reaches cfg_timeout_i without acq_done_i: timeout_o = 1 for one cycle and return to IDLE. done_src_o is updated; done_o is not pulsed.
  - If acq_done_i and timeout coincide, done wins.
- DONE:
  - done_o = 1 for one cycle and done_src_o = src.
  - Return to IDLE. A new grant is possible on the following cycle.
  - done_src_o holds until the next completion or timeout.
- Minimum sequence with cnv_high = 1, wait = 0 and acq_done on the first ACQ cycle: grant → CNV → ACQ → DONE → IDLE, 4 cycles per conversion.
- Deasserting enable_i mid-sequence does not abort; it only blocks the next grant.
- ARESETN asserted mid-sequence: immediate return to reset values; cnv_o drops asynchronously.

Test Plan:
- Single request: pulse req_i = 0001 with cnv_high = 3, wait = 5, acq_done 10 cycles after acq_start.
  - cnv_o high 3 cycles.
  - acq_start 5 cycles after cnv_o falls.
  - done_o 1 cycle after acq_done; done_src_o = 0; busy_o low afterwards.
- Round-robin: req_i = 1111 in one cycle, acq_done immediate → done_src_o sequence 0, 1, 2, 3; pending_o steps 1110 → 1100 → 1000 → 0000.
- Fairness: source 0 re-requests every cycle while source 2 requests once → grants alternate 0, 2, 0, …; overrun_o[0] pulses while pending[0] is already set.
- Timeout: timeout = 20, acq_done never arrives → timeout_o pulses 20 cycles after acq_start; no done_o; FSM returns to IDLE; next pending request is granted.
- Boundaries:
  - cnv_high = 0 → cnv_o high 1 cycle.
  - wait = 0 → acq_start on the cycle after cnv_o falls.
  - acq_done coinciding with the timeout cycle → done_o, no timeout_o.
- Enable and reset:
  - enable_i = 0 with req_i = 0010 → no grant, pending_o = 0010; raising enable_i starts the sequence.
  - ARESETN low during WAIT → cnv_o = 0, busy_o = 0, pending_o = 0 immediately.
